// File: rtl/router_pkg.sv
// Shared router constants and frame transmitter state encoding.
package router_pkg;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned N_CHAN = 8;

   typedef logic [2:0] tx_state_t;

   localparam tx_state_t IDLE  = 3'd0;
   localparam tx_state_t ADDR  = 3'd1;
   localparam tx_state_t WAIT  = 3'd2;
   localparam tx_state_t PAYLD = 3'd3;
   localparam tx_state_t GAP   = 3'd4;

   // Reversed so an LSB-first shifter emits the destination MSB first.
   function automatic logic [ADDR_W-1:0] rev_dest(input logic [ADDR_W-1:0] d);
      return {d[0], d[1], d[2]};
   endfunction

endpackage

// File: rtl/frame_tx_shreg.sv
// Load/shift-right register with a down-counting bit counter; serves address and payload phases.
module frame_tx_shreg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic [CNT_W-1:0] load_len_i,
   output logic             bit_o,
   output logic             last_o
);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load_i) begin
         sr_d  = load_val_i;
         cnt_d = load_len_i;
      end else if (shift_i) begin
         sr_d = sr_q >> 1;
         if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign bit_o  = sr_q[0];
   assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/frame_tx.sv
// Serial frame transmitter: address, pad while busy, LSB-first payload, inter-frame gap.
// Optional busy timeout abort enabled by defining FRAME_TX_TIMEOUT_EN.
module frame_tx
   import router_pkg::*;
#(
   parameter int unsigned PAYLOAD_W = 8,
   parameter int unsigned WAIT_MIN  = 2,
   parameter int unsigned GAP_CYC   = 1,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [2:0]           req_dest,
   input  logic [PAYLOAD_W-1:0] req_data,
   input  logic                 busy,
   output logic                 valid,
   output logic                 stream,
   output logic                 tx_active,
   output logic                 done,
   output logic                 err
);

   localparam int unsigned SR_W   = (PAYLOAD_W > ADDR_W) ? PAYLOAD_W : ADDR_W;
   localparam int unsigned BIT_W  = $clog2(SR_W + 1);
`ifdef FRAME_TX_TIMEOUT_EN
   localparam int unsigned WAIT_MAX = (TIMEOUT > WAIT_MIN) ? TIMEOUT : WAIT_MIN;
`else
   localparam int unsigned WAIT_MAX = WAIT_MIN;
`endif
   localparam int unsigned WCNT_W = $clog2(WAIT_MAX + 1);
   localparam int unsigned GCNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   tx_state_t             state_q, state_d;
   logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
   logic [GCNT_W-1:0]     gcnt_q, gcnt_d;
   logic [PAYLOAD_W-1:0]  data_q, data_d;
   logic                  ready_q;
   logic                  abort_q, abort_d;

   logic                  sr_load, sr_shift, sr_bit, sr_last;
   logic [SR_W-1:0]       sr_val;
   logic [BIT_W-1:0]      sr_len;

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      gcnt_d   = gcnt_q;
      data_d   = data_q;
      abort_d  = abort_q;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
      sr_val   = SR_W'(rev_dest(req_dest));
      sr_len   = BIT_W'(ADDR_W);
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               sr_load = 1'b1;
               data_d  = req_data;
               abort_d = 1'b0;
               state_d = ADDR;
            end
         end
         ADDR: begin
            sr_shift = 1'b1;
            if (sr_last) begin
               wcnt_d  = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q >= WCNT_W'(WAIT_MIN - 1) && !busy) begin
               sr_load = 1'b1;
               sr_val  = SR_W'(data_q);
               sr_len  = BIT_W'(PAYLOAD_W);
               state_d = PAYLD;
            end
`ifdef FRAME_TX_TIMEOUT_EN
            else if (busy && wcnt_q >= WCNT_W'(TIMEOUT - 1)) begin
               gcnt_d  = '0;
               abort_d = 1'b1;
               state_d = GAP;
            end
`endif
         end
         PAYLD: begin
            sr_shift = 1'b1;
            if (sr_last) begin
               gcnt_d  = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            gcnt_d = gcnt_q + 1'b1;
            if (gcnt_q == GCNT_W'(GAP_CYC - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         gcnt_q  <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         gcnt_q  <= gcnt_d;
         data_q  <= data_d;
         ready_q <= 1'b1;
         abort_q <= abort_d;
      end
   end

   frame_tx_shreg #(
      .WIDTH (SR_W),
      .CNT_W (BIT_W)
   ) u_shreg (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (sr_load),
      .shift_i    (sr_shift),
      .load_val_i (sr_val),
      .load_len_i (sr_len),
      .bit_o      (sr_bit),
      .last_o     (sr_last)
   );

   assign valid     = (state_q == ADDR) || (state_q == WAIT) || (state_q == PAYLD);
   assign tx_active = valid;
   assign stream    = ((state_q == ADDR) || (state_q == PAYLD)) && sr_bit;
   // ready_q keeps req_ready low for the first cycle after reset releases.
   assign req_ready = (state_q == IDLE) && ready_q;
   assign done      = (state_q == GAP) && (gcnt_q == '0) && !abort_q;
`ifdef FRAME_TX_TIMEOUT_EN
   assign err       = (state_q == GAP) && (gcnt_q == '0) && abort_q;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_frame_tx.sv
// Directed self-checking bench for frame_tx at default parameters.
module tb_frame_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_dest;
   logic [7:0] req_data;
   logic       busy;
   logic       valid;
   logic       stream;
   logic       tx_active;
   logic       done;
   logic       err;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   frame_tx #(
      .PAYLOAD_W (8),
      .WAIT_MIN  (2),
      .GAP_CYC   (1),
      .TIMEOUT   (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_dest  (req_dest),
      .req_data  (req_data),
      .busy      (busy),
      .valid     (valid),
      .stream    (stream),
      .tx_active (tx_active),
      .done      (done),
      .err       (err)
   );

   // Expected stream bit at frame cycle k (1 = first address cycle), payload starting at pstart.
   function automatic logic exp_bit(input int k, input logic [2:0] d, input logic [7:0] x,
                                    input int pstart);
      if (k >= 1 && k <= 3) return d[3-k];
      if (k >= pstart && k < pstart + 8) return x[k-pstart];
      return 1'b0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; busy = 1'b0; req_dest = '0; req_data = '0;
      repeat (3) step();
      n_total++;
      if ({valid, stream, tx_active, done, err, req_ready} !== 6'b0)
         $display("FAIL reset_outputs got %b exp 000000",
                  {valid, stream, tx_active, done, err, req_ready});
      else n_pass++;
      rst = 1'b0;
      n_total++;
      if (req_ready !== 1'b0) $display("FAIL reset_ready_low got %b exp 0", req_ready);
      else n_pass++;
      step();
      n_total++;
      if ({req_ready, valid, done} !== 3'b100)
         $display("FAIL reset_ready_rise got %b exp 100", {req_ready, valid, done});
      else n_pass++;
   endtask

   task automatic test_nominal(input logic [2:0] d, input logic [7:0] x);
      logic [5:0] exp_v;
      req_dest = d; req_data = x; req_valid = 1'b1;
      n_total++;
      if (req_ready !== 1'b1) $display("FAIL nominal_ready0 got %b exp 1", req_ready);
      else n_pass++;
      step();
      req_valid = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         if (c > 1) step();
         exp_v = {c <= 13, exp_bit(c, d, x, 6), c <= 13, c == 14, c == 15, 1'b0};
         n_total++;
         if ({valid, stream, tx_active, done, req_ready, err} !== exp_v)
            $display("FAIL nominal d=%0d x=%h c=%0d got %b exp %b", d, x, c,
                     {valid, stream, tx_active, done, req_ready, err}, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_busy_stall();
      logic [5:0] exp_v;
      req_dest = 3'd2; req_data = 8'h3C; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      for (int c = 1; c <= 23; c++) begin
         if (c > 1) step();
         exp_v = {c <= 21, exp_bit(c, 3'd2, 8'h3C, 14), c <= 21, c == 22, c == 23, 1'b0};
         n_total++;
         if ({valid, stream, tx_active, done, req_ready, err} !== exp_v)
            $display("FAIL busy_stall c=%0d got %b exp %b", c,
                     {valid, stream, tx_active, done, req_ready, err}, exp_v);
         else n_pass++;
         busy = (c >= 3 && c <= 12);
      end
      busy = 1'b0;
   endtask

   task automatic test_mid_reset();
      req_dest = 3'd3; req_data = 8'hFF; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      for (int c = 2; c <= 10; c++) step();
      n_total++;
      if ({valid, stream} !== 2'b11)
         $display("FAIL mid_reset_bit4 got %b exp 11", {valid, stream});
      else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_total++;
      if ({valid, tx_active, done, req_ready, err} !== 5'b0)
         $display("FAIL mid_reset_drop got %b exp 00000", {valid, tx_active, done, req_ready, err});
      else n_pass++;
      step();
      n_total++;
      if ({req_ready, done, valid} !== 3'b100)
         $display("FAIL mid_reset_ready got %b exp 100", {req_ready, done, valid});
      else n_pass++;
      test_nominal(3'd6, 8'h5A);
   endtask

   task automatic test_back_to_back();
      int         acc;
      int         k;
      logic [2:0] d;
      logic [7:0] x;
      logic [1:0] exp_v;
      acc = -1;
      req_dest = 3'd7; req_data = 8'hC3; req_valid = 1'b1;
      step();
      req_dest = 3'd0; req_data = 8'h96;
      for (int c = 1; c <= 31; c++) begin
         if (c > 1) step();
         if (c >= 16) req_valid = 1'b0;
         if (acc < 0 && req_ready && req_valid) acc = c;
         if (c <= 15) begin k = c; d = 3'd7; x = 8'hC3; end
         else begin k = c - 15; d = 3'd0; x = 8'h96; end
         exp_v = {k <= 13, exp_bit(k, d, x, 6)};
         n_total++;
         if ({valid, stream} !== exp_v)
            $display("FAIL back_to_back c=%0d got %b exp %b", c, {valid, stream}, exp_v);
         else n_pass++;
      end
      req_valid = 1'b0;
      n_total++;
      if (acc != 15) $display("FAIL b2b_accept_cycle got %0d exp 15", acc);
      else n_pass++;
   endtask

   task automatic test_wait_hold();
      logic [4:0] exp_v;
      req_dest = 3'd1; req_data = 8'h0F; req_valid = 1'b1; busy = 1'b1;
      step();
      req_valid = 1'b0;
`ifdef FRAME_TX_TIMEOUT_EN
      for (int c = 1; c <= 70; c++) begin
         if (c > 1) step();
         exp_v = {c <= 67, exp_bit(c, 3'd1, 8'h0F, 1000), 1'b0, c == 68, c == 69};
         n_total++;
         if ({valid, stream, done, err, req_ready} !== exp_v)
            $display("FAIL timeout c=%0d got %b exp %b", c,
                     {valid, stream, done, err, req_ready}, exp_v);
         else n_pass++;
      end
      busy = 1'b0;
`else
      for (int c = 1; c <= 215; c++) begin
         if (c > 1) step();
         exp_v = {c <= 213, exp_bit(c, 3'd1, 8'h0F, 206), c == 214, 1'b0, c == 215};
         n_total++;
         if ({valid, stream, done, err, req_ready} !== exp_v)
            $display("FAIL wait_hold c=%0d got %b exp %b", c,
                     {valid, stream, done, err, req_ready}, exp_v);
         else n_pass++;
         busy = (c < 205);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_nominal(3'd5, 8'hA5);
      test_busy_stall();
      test_mid_reset();
      test_back_to_back();
      test_wait_hold();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
